jk_updown_modn_counter: RTL

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and cascade terminal-count output. It generalises the team's fixed-direction JK counters: width is a parameter, the wrap point is a run-time input rather than a compare-and-clear, and the counter counts in both directions. It is a drop-in timebase or divider stage, and wider counts are built by chaining `tc` of one instance into `en` of the next.

---
 rtl/jk_updown_modn_counter.sv | 77 +++++++
 1 files changed

// File: rtl/jk_updown_modn_counter.sv
// Up/down counter with run-time modulus (0..mod_value), parallel load, enable
// and a combinational terminal count for cascading stages.
module jk_updown_modn_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         CLR,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] mod_value,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] toggle;
  logic         wrap_q;
  logic         wrap_d;
  logic         at_top;
  logic         at_bottom;

  // JK cell: J sets, K clears, J=K toggles.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

  // ">=" so that counts left above a lowered or loaded modulus still wrap up.
  assign at_top    = (count_q >= mod_value);
  assign at_bottom = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + W'(1);
        end
      end else begin
        if (at_bottom) begin
          count_d = mod_value;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - W'(1);
        end
      end
    end
  end

  assign toggle = count_q ^ count_d;

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      for (int i = 0; i < W; i++) begin
        count_q[i] <= jk_next(count_q[i], toggle[i], toggle[i]);
      end
      wrap_q <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign tc    = en & ~load & ((up & at_top) | (~up & at_bottom));

endmodule
